jedro_1_mem_arbiter: RTL
========================

JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all registers are rising-edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port m0_req_i, input, 1, instruction-fetch read request.
REQ-007 SHALL have port m0_addr_i, input, ADDR_WIDTH, instruction-fetch address.
REQ-008 SHALL have port m0_gnt_o, output, 1, m0 request accepted this cycle.
REQ-009 SHALL have ports m0_rvalid_o (output, 1) and m0_rdata_o (output, DATA_WIDTH), the m0 read response.
REQ-010 SHALL have ports m1_req_i (input, 1), m1_we_i (input, 1), m1_be_i (input, DATA_WIDTH/8), m1_addr_i (input, ADDR_WIDTH) and m1_wdata_i (input, DATA_WIDTH), the load/store request.
REQ-011 SHALL have ports m1_gnt_o (output, 1), m1_rvalid_o (output, 1) and m1_rdata_o (output, DATA_WIDTH), the load/store grant and response.
REQ-012 SHALL have ports ram_en_o (output, 1), ram_we_o (output, DATA_WIDTH/8), ram_addr_o (output, ADDR_WIDTH) and ram_wdata_o (output, DATA_WIDTH), the shared single-port RAM command.
REQ-013 SHALL have port ram_rdata_i, input, DATA_WIDTH, RAM read data with 1-cycle latency after ram_en_o.
REQ-014 SHALL have port conflict_cnt_o, output, 16, count of cycles in which both requesters were active.

Function
REQ-015 SHALL grant at most one requester per cycle, combinationally from the current req inputs; m0_gnt_o and m1_gnt_o are never both 1.
REQ-016 SHALL grant the only active requester when exactly one of m0_req_i or m1_req_i is 1.
REQ-017 SHALL resolve a conflict (both req=1) round-robin: the winner is the requester not recorded in the rr_last register.
REQ-018 SHALL update rr_last to the granted requester on every grant, and hold it when there is no grant.
REQ-019 SHALL, while a grant is active, drive ram_en_o=1, ram_addr_o=winner address, ram_we_o=m1_be_i if (m1 granted and m1_we_i=1) else 0, and ram_wdata_o=m1_wdata_i.
REQ-020 SHALL drive ram_en_o=0 and ram_we_o=0 when there is no grant; ram_addr_o and ram_wdata_o are don't-care in that case.
REQ-021 SHALL register the response owner (NONE/M0/M1) each cycle as the state machine: owner <= granted requester, or NONE.
REQ-022 SHALL assert rvalid for one cycle on the owner's port exactly one cycle after its grant, for both reads and writes (write acknowledge).
REQ-023 SHALL route ram_rdata_i to both m0_rdata_o and m1_rdata_o unmodified; the data is valid only where rvalid=1.
REQ-024 SHALL support back-to-back grants on every cycle with no bubble, including alternating owners (e.g. M1 then M0: m1_rvalid_o at t+1, m0_rvalid_o at t+2).
REQ-025 SHALL increment conflict_cnt_o by 1 on each conflict cycle and saturate at 0xFFFF (no wrap).
REQ-026 SHALL require a requester to hold req/addr/we/be/wdata stable until it is granted; a request dropped before grant is discarded silently.

Reset
REQ-027 SHALL, while rst_i=1, force m0_gnt_o=0, m1_gnt_o=0, ram_en_o=0 and ram_we_o=0, ignoring the req inputs.
REQ-028 SHALL asynchronously reset owner=NONE (m0_rvalid_o=0, m1_rvalid_o=0), rr_last=M0 (first conflict goes to M1) and conflict_cnt_o=0.
REQ-029 SHALL drop a response pending at reset assertion; no rvalid appears after rst_i deasserts.

Verification
REQ-030 SHALL pass: only m0_req_i=1 with addr 0x10 and ram_rdata_i=0x00100093 -> m0_gnt_o=1 in the same cycle, and m0_rvalid_o=1 with m0_rdata_o=0x00100093 in the next cycle.
REQ-031 SHALL pass: both requesters held for 4 cycles after reset -> grant order M1,M0,M1,M0; conflict_cnt_o=4.
REQ-032 SHALL pass: m1 write with be=4'b0011, addr 0x40 and wdata 0xDEADBEEF -> ram_we_o=4'b0011 and ram_wdata_o=0xDEADBEEF in the grant cycle, then m1_rvalid_o=1 for one cycle.
REQ-033 SHALL pass: rst_i asserted the cycle after an m1 grant -> m1_rvalid_o stays 0, and after release the first conflict grants M1.
REQ-034 SHALL pass: conflict_cnt_o preloaded to 0xFFFE via 2 further conflict cycles -> 0xFFFF, and it stays 0xFFFF on a third conflict.
REQ-035 SHALL pass: random requests for 10k cycles -> never both grants, every grant yields exactly one rvalid to the correct port 1 cycle later.

Source files
------------

// File: rtl/jedro_1_mem_arbiter.sv
// Two-master arbiter for a shared single-port RAM: instruction fetch (m0) and load/store (m1).
// Conflicts alternate between masters; each grant yields one rvalid pulse on the owner's port one cycle later.
module jedro_1_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // instruction fetch (read only)
  input  logic                      m0_req_i,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  output logic                      m0_gnt_o,
  output logic                      m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  // load/store
  input  logic                      m1_req_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic                      m1_gnt_o,
  output logic                      m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  // shared RAM
  output logic                      ram_en_o,
  output logic [DATA_WIDTH/8-1:0]   ram_we_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  output logic [15:0]               conflict_cnt_o
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } owner_e;

  typedef enum logic {
    RR_M0,
    RR_M1
  } rr_e;

  owner_e      owner_q, owner_d;
  rr_e         rr_last_q, rr_last_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        gnt0, gnt1, conflict;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    conflict = m0_req_i & m1_req_i & ~rst_i;
    if (!rst_i) begin
      if (conflict) begin
        // winner is whichever master did not win last time
        if (rr_last_q == RR_M0) gnt1 = 1'b1;
        else                    gnt0 = 1'b1;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  always_comb begin
    ram_en_o    = gnt0 | gnt1;
    ram_addr_o  = gnt1 ? m1_addr_i : m0_addr_i;
    ram_we_o    = (gnt1 && m1_we_i) ? m1_be_i : '0;
    ram_wdata_o = m1_wdata_i;
  end

  always_comb begin
    rr_last_d      = rr_last_q;
    owner_d        = OWN_NONE;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt1) begin
      rr_last_d = RR_M1;
      owner_d   = OWN_M1;
    end else if (gnt0) begin
      rr_last_d = RR_M0;
      owner_d   = OWN_M0;
    end
    if (conflict && (conflict_cnt_q != 16'hFFFF)) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q        <= OWN_NONE;
      rr_last_q      <= RR_M0;
      conflict_cnt_q <= '0;
    end else begin
      owner_q        <= owner_d;
      rr_last_q      <= rr_last_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign m0_gnt_o       = gnt0;
  assign m1_gnt_o       = gnt1;
  assign m0_rvalid_o    = (owner_q == OWN_M0);
  assign m1_rvalid_o    = (owner_q == OWN_M1);
  assign m0_rdata_o     = ram_rdata_i;
  assign m1_rdata_o     = ram_rdata_i;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
